// File: rtl/serv_seq_pkg.sv
// Shared types and width helpers for the serial-core instruction sequencer.
// The state encoding is 3 bits wide so that it can be exported on the debug port.
package serv_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_RDWAIT = 3'd1,
    ST_INIT   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EXEC   = 3'd4
  } state_e;

  // Number of beats per 32-bit instruction at datapath width w.
  function automatic int nb_of(input int w);
    return 32 / w;
  endfunction

  // Beat counter width. It is never zero, so the counter still exists when W=32.
  function automatic int beat_w(input int w);
    return (32 / w > 1) ? $clog2(32 / w) : 1;
  endfunction

endpackage

// File: rtl/serv_seq_if.sv
// Handshake bundle between the sequencer and the ibus, dbus, RF and MDU ports.
interface serv_seq_if;
  logic o_ibus_cyc;
  logic i_ibus_ack;
  logic o_dbus_cyc;
  logic i_dbus_ack;
  logic o_rf_rreq;
  logic o_rf_wreq;
  logic i_rf_ready;
  logic o_mdu_valid;
  logic i_mdu_ready;

  modport master (
    output o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_mdu_valid,
    input  i_ibus_ack, i_dbus_ack, i_rf_ready, i_mdu_ready
  );

  modport slave (
    input  o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_mdu_valid,
    output i_ibus_ack, i_dbus_ack, i_rf_ready, i_mdu_ready
  );
endinterface

// File: rtl/serv_beat_cnt.sv
// Beat counter for the serial datapath: advances on enable and wraps to 0 after
// beat NB-1. Holding the enable low freezes it, which is how a stall is absorbed.
module serv_beat_cnt #(
  parameter int NB = 32,
  parameter int BW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [BW-1:0] o_beat,
  output logic          o_first,
  output logic          o_last
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  logic [BW-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (i_en) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only; blocking here would
  // let other flops sampling beat_q in the same edge see the updated value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) beat_q <= '0;
    else       beat_q <= beat_d;
  end

  assign o_beat  = beat_q;
  assign o_first = (beat_q == '0);
  assign o_last  = (beat_q == LAST_BEAT);

endmodule

// File: rtl/serv_seq.sv
// Instruction sequencer for the bit/nibble/byte-serial core: fetch, RF read,
// optional INIT pass, memory/MDU/shift wait, then the EXEC pass.
module serv_seq
  import serv_seq_pkg::*;
#(
  parameter int W        = 1,
  parameter int WITH_CSR = 1,
  parameter int ALIGN    = 0,
  parameter int MDU      = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  serv_seq_if.master        bus,
  input  logic              i_stall,
  input  logic              i_two_stage_op,
  input  logic              i_branch_op,
  input  logic              i_cond_branch,
  input  logic              i_bne_or_bge,
  input  logic              i_alu_cmp,
  input  logic              i_dbus_en,
  input  logic              i_mem_misalign,
  input  logic              i_ctrl_misalign,
  input  logic              i_e_op,
  input  logic              i_new_irq,
  input  logic              i_sh_done,
  input  logic              i_slt_or_branch,
  input  logic              i_mdu_op,
  output logic              o_init,
  output logic              o_cnt_en,
  output logic [4:0]        o_cnt,
  output logic              o_cnt0,
  output logic              o_cnt_done,
  output logic              o_ctrl_pc_en,
  output logic              o_ctrl_jump,
  output logic              o_ctrl_trap,
  output logic [1:0]        o_mem_bytecnt,
  output logic [2:0]        o_state
);

  localparam int NB = nb_of(W);
  localparam int BW = beat_w(W);
  localparam int LW = $clog2(W);

  localparam logic CSR_EN   = (WITH_CSR != 0);
  localparam logic ALIGN_EN = (ALIGN != 0);
  localparam logic MDU_EN   = (MDU != 0);

  state_e state_q, state_d;
  logic   jump_q, jump_d;
  logic   trap_q, trap_d;
  logic   stage2_q, stage2_d;

  logic          counting, cnt_en, cnt_last;
  logic [BW-1:0] beat;
  logic          beat_first, beat_last;
  logic          take_branch, trap_pending, wait_done;
  logic          rf_rreq, rf_wreq, dbus_cyc, mdu_valid;

  assign counting = (state_q == ST_INIT) || (state_q == ST_EXEC);
  assign cnt_en   = counting & ~i_stall;
  assign cnt_last = cnt_en & beat_last;

  serv_beat_cnt #(.NB(NB), .BW(BW)) u_beat_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (cnt_en),
    .o_beat  (beat),
    .o_first (beat_first),
    .o_last  (beat_last)
  );

  assign take_branch  = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
  assign trap_pending = CSR_EN & ((take_branch & i_ctrl_misalign & ~ALIGN_EN) |
                                  (i_dbus_en & i_mem_misalign));
  assign wait_done    = bus.i_dbus_ack | (MDU_EN & bus.i_mdu_ready) | i_sh_done | i_slt_or_branch;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d   = state_q;
    jump_d    = jump_q;
    trap_d    = trap_q;
    stage2_d  = stage2_q;
    rf_rreq   = 1'b0;
    rf_wreq   = 1'b0;
    dbus_cyc  = 1'b0;
    mdu_valid = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (bus.i_ibus_ack) begin
          rf_rreq = 1'b1;
          state_d = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        if (bus.i_rf_ready) begin
          stage2_d = 1'b0;
          state_d  = (i_two_stage_op & ~i_new_irq & ~stage2_q) ? ST_INIT : ST_EXEC;
        end
      end
      ST_INIT: begin
        if (cnt_last) begin
          state_d = ST_WAIT;
          jump_d  = take_branch;
          trap_d  = trap_pending;
        end
      end
      ST_WAIT: begin
        // Coming back through RDWAIT with stage2 set sends the instruction to EXEC.
        stage2_d = 1'b1;
        if (trap_q) begin
          rf_rreq = 1'b1;
          state_d = ST_RDWAIT;
        end else begin
          dbus_cyc  = i_dbus_en & ~i_mem_misalign;
          mdu_valid = MDU_EN & i_mdu_op;
          if (wait_done) begin
            rf_wreq = 1'b1;
            state_d = ST_RDWAIT;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_last) begin
          state_d = ST_FETCH;
          jump_d  = 1'b0;
          trap_d  = 1'b0;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_FETCH;
      jump_q   <= 1'b0;
      trap_q   <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      jump_q   <= jump_d;
      trap_q   <= trap_d;
      stage2_q <= stage2_d;
    end
  end

  assign bus.o_ibus_cyc  = (state_q == ST_FETCH) & ~i_rst;
  assign bus.o_dbus_cyc  = dbus_cyc;
  assign bus.o_rf_rreq   = rf_rreq;
  assign bus.o_rf_wreq   = rf_wreq;
  assign bus.o_mdu_valid = mdu_valid;

  // Beat index scaled to a bit index; at W=32 the shift leaves only zeros.
  assign o_cnt         = 5'(beat) << LW;
  assign o_mem_bytecnt = o_cnt[4:3];
  assign o_init        = (state_q == ST_INIT);
  assign o_cnt_en      = cnt_en;
  assign o_cnt0        = cnt_en & beat_first;
  assign o_cnt_done    = cnt_last;
  assign o_ctrl_pc_en  = cnt_en & ~o_init;
  assign o_ctrl_jump   = jump_q;
  assign o_ctrl_trap   = CSR_EN & (i_e_op | i_new_irq | trap_q);
  assign o_state       = state_q;

endmodule

// File: tb/tb_serv_seq.sv
// Bench for serv_seq at W=1,2,4,8,32. Each instruction is expanded into a list of
// per-cycle input/expected-output records built from the phase rules, then replayed.
module tb_serv_seq;

  localparam int NI = 5;
  localparam int WS [NI] = '{1, 2, 4, 8, 32};

  typedef struct packed {
    logic ibus_ack, dbus_ack, rf_ready, stall;
    logic two_stage, branch, cond, bne, alu_cmp;
    logic dbus_en, mem_mis, ctrl_mis, e_op, irq;
    logic sh_done, slt, mdu_op, mdu_ready;
  } in_t;

  typedef struct packed {
    logic       ibus_cyc, dbus_cyc, rf_rreq, rf_wreq, mdu_valid, init, cnt_en;
    logic [4:0] cnt;
    logic       cnt0, cnt_done, pc_en, jump, trap;
    logic [1:0] bytecnt;
  } out_t;

  typedef struct {
    int    k;
    in_t   i;
    out_t  o;
    string tag;
  } rec_t;

  typedef struct {
    int k;
    bit two_stage, branch, cond, bne, alu_cmp, dbus_en, mem_mis, ctrl_mis, e_op, irq, mdu_op;
    int fetch_dly, rd_dly, wait_dly, ev, stall_pct, stall_beat, stall_len;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  in_t  in_cur = '0;
  int   sel = 0;
  out_t obs [NI];

  rec_t  q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    m_jump, m_trap;
  int    m_k;
  string m_tag;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serv_seq_if bus ();
    logic       o_init, o_cnt_en, o_cnt0, o_cnt_done, o_pc_en, o_jump, o_trap;
    logic [4:0] o_cnt;
    logic [1:0] o_bytecnt;
    logic [2:0] o_state;

    assign bus.i_ibus_ack  = in_cur.ibus_ack  & (sel == g);
    assign bus.i_dbus_ack  = in_cur.dbus_ack  & (sel == g);
    assign bus.i_rf_ready  = in_cur.rf_ready  & (sel == g);
    assign bus.i_mdu_ready = in_cur.mdu_ready & (sel == g);

    serv_seq #(
      .W(WS[g]), .WITH_CSR(1), .ALIGN(g == 4 ? 1 : 0), .MDU(g == 4 ? 1 : 0)
    ) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus.master),
      .i_stall(in_cur.stall), .i_two_stage_op(in_cur.two_stage),
      .i_branch_op(in_cur.branch), .i_cond_branch(in_cur.cond),
      .i_bne_or_bge(in_cur.bne), .i_alu_cmp(in_cur.alu_cmp),
      .i_dbus_en(in_cur.dbus_en), .i_mem_misalign(in_cur.mem_mis),
      .i_ctrl_misalign(in_cur.ctrl_mis), .i_e_op(in_cur.e_op),
      .i_new_irq(in_cur.irq), .i_sh_done(in_cur.sh_done & (sel == g)),
      .i_slt_or_branch(in_cur.slt & (sel == g)), .i_mdu_op(in_cur.mdu_op),
      .o_init(o_init), .o_cnt_en(o_cnt_en), .o_cnt(o_cnt), .o_cnt0(o_cnt0),
      .o_cnt_done(o_cnt_done), .o_ctrl_pc_en(o_pc_en), .o_ctrl_jump(o_jump),
      .o_ctrl_trap(o_trap), .o_mem_bytecnt(o_bytecnt), .o_state(o_state)
    );

    assign obs[g] = {bus.o_ibus_cyc, bus.o_dbus_cyc, bus.o_rf_rreq, bus.o_rf_wreq,
                     bus.o_mdu_valid, o_init, o_cnt_en, o_cnt, o_cnt0, o_cnt_done,
                     o_pc_en, o_jump, o_trap, o_bytecnt};
  end

  task automatic check(input int k, input string tag, input out_t exp);
    n_cmp++;
    assert (obs[k] === exp)
    else begin
      n_bad++;
      $error("FAIL %s w=%0d t=%0t observed=%h expected=%h", tag, WS[k], $time, obs[k], exp);
    end
  endtask

  function automatic in_t noise(input in_t b);
    in_t r = b;
    r.ibus_ack  = 1'($urandom_range(0, 1));
    r.rf_ready  = 1'($urandom_range(0, 1));
    r.dbus_ack  = 1'($urandom_range(0, 1));
    r.sh_done   = 1'($urandom_range(0, 1));
    r.slt       = 1'($urandom_range(0, 1));
    r.mdu_ready = 1'($urandom_range(0, 1));
    r.stall     = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic in_t no_events(input in_t b);
    in_t r = b;
    r.dbus_ack = 1'b0; r.sh_done = 1'b0; r.slt = 1'b0; r.mdu_ready = 1'b0;
    return r;
  endfunction

  function automatic out_t base_out(input instr_t d);
    out_t o = '0;
    o.jump = m_jump;
    o.trap = d.e_op | d.irq | m_trap;
    return o;
  endfunction

  task automatic push(input in_t i, input out_t o);
    rec_t r;
    r.k = m_k; r.i = i; r.o = o; r.tag = m_tag;
    q.push_back(r);
  endtask

  task automatic rdwait(input in_t b, input instr_t d);
    in_t i;
    m_tag = "rdwait";
    repeat (d.rd_dly) begin
      i = noise(b); i.rf_ready = 1'b0;
      push(i, base_out(d));
    end
    i = noise(b); i.rf_ready = 1'b1;
    push(i, base_out(d));
  endtask

  task automatic count_phase(input in_t b, input instr_t d, input bit init);
    int   w = WS[d.k];
    int   nb = 32 / w;
    in_t  i;
    out_t o;
    m_tag = init ? "init" : "exec";
    for (int bt = 0; bt < nb; bt++) begin
      int ns = (bt == d.stall_beat) ? d.stall_len : 0;
      while (d.stall_pct > 0 && ns < 3 && $urandom_range(0, 99) < d.stall_pct) ns++;
      o = base_out(d);
      o.init    = init;
      o.cnt     = 5'(bt * w);
      o.bytecnt = 2'((bt * w) >> 3);
      repeat (ns) begin
        i = noise(b); i.stall = 1'b1;
        push(i, o);
      end
      i = noise(b); i.stall = 1'b0;
      o.cnt_en   = 1'b1;
      o.cnt0     = (bt == 0);
      o.cnt_done = (bt == nb - 1);
      o.pc_en    = !init;
      push(i, o);
    end
  endtask

  // Expand one instruction into its expected cycle-by-cycle behaviour.
  task automatic gen_instr(input instr_t d);
    bit   has_mdu = (d.k == 4);
    bit   aligned = (d.k == 4);
    bit   tb_take, tp;
    int   ev;
    in_t  b, i;
    out_t o;
    m_k = d.k; m_jump = 1'b0; m_trap = 1'b0;
    b = '0;
    b.two_stage = d.two_stage; b.branch = d.branch; b.cond = d.cond; b.bne = d.bne;
    b.alu_cmp = d.alu_cmp; b.dbus_en = d.dbus_en; b.mem_mis = d.mem_mis;
    b.ctrl_mis = d.ctrl_mis; b.e_op = d.e_op; b.irq = d.irq; b.mdu_op = d.mdu_op;

    m_tag = "fetch";
    repeat (d.fetch_dly) begin
      i = noise(b); i.ibus_ack = 1'b0;
      o = base_out(d); o.ibus_cyc = 1'b1;
      push(i, o);
    end
    i = noise(b); i.ibus_ack = 1'b1;
    o = base_out(d); o.ibus_cyc = 1'b1; o.rf_rreq = 1'b1;
    push(i, o);
    rdwait(b, d);

    if (d.two_stage && !d.irq) begin
      count_phase(b, d, 1'b1);
      tb_take = d.branch && (!d.cond || (d.alu_cmp != d.bne));
      tp      = (tb_take && d.ctrl_mis && !aligned) || (d.dbus_en && d.mem_mis);
      m_jump  = tb_take;
      m_trap  = tp;
      m_tag   = "wait";
      if (tp) begin
        o = base_out(d); o.rf_rreq = 1'b1;
        push(noise(b), o);
      end else begin
        o = base_out(d);
        o.dbus_cyc  = d.dbus_en && !d.mem_mis;
        o.mdu_valid = has_mdu && d.mdu_op;
        repeat (d.wait_dly) push(no_events(noise(b)), o);
        i  = no_events(noise(b));
        ev = (d.ev == 1 && !has_mdu) ? 2 : d.ev;
        case (ev)
          0:       i.dbus_ack  = 1'b1;
          1:       i.mdu_ready = 1'b1;
          2:       i.sh_done   = 1'b1;
          default: i.slt       = 1'b1;
        endcase
        o.rf_wreq = 1'b1;
        push(i, o);
      end
      rdwait(b, d);
    end

    count_phase(b, d, 1'b0);
    m_jump = 1'b0;
    m_trap = 1'b0;
  endtask

  task automatic run_q(input int n);
    rec_t r;
    int   done = 0;
    while (q.size() > 0 && (n < 0 || done < n)) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      sel    = r.k;
      in_cur = r.i;
      @(negedge clk);
      check(r.k, r.tag, r.o);
      done++;
    end
  endtask

  function automatic instr_t blank(input int k);
    instr_t d;
    d = '{k: k, two_stage: 0, branch: 0, cond: 0, bne: 0, alu_cmp: 0, dbus_en: 0,
          mem_mis: 0, ctrl_mis: 0, e_op: 0, irq: 0, mdu_op: 0, fetch_dly: 0, rd_dly: 0,
          wait_dly: 0, ev: 2, stall_pct: 0, stall_beat: -1, stall_len: 0};
    return d;
  endfunction

  initial begin
    instr_t d;
    out_t   exp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check(k, "reset", '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp = '0; exp.ibus_cyc = 1'b1;
    for (int k = 0; k < NI; k++) check(k, "post_reset", exp);

    // W=1 ALU op: 32 counting cycles, then straight back to fetch.
    d = blank(0); d.fetch_dly = 1; d.rd_dly = 1;
    gen_instr(d); run_q(-1);

    // W=4 taken beq: INIT pass, compare latched into the jump flag.
    d = blank(2); d.two_stage = 1; d.branch = 1; d.cond = 1; d.alu_cmp = 1; d.ev = 3;
    gen_instr(d); run_q(-1);

    // W=8 misaligned load: trap path through WAIT, no data cycle.
    d = blank(3); d.two_stage = 1; d.dbus_en = 1; d.mem_mis = 1;
    gen_instr(d); run_q(-1);

    // W=2 stall at beat 5 for 3 cycles.
    d = blank(1); d.stall_beat = 5; d.stall_len = 3;
    gen_instr(d); run_q(-1);

    // W=1 load: data ack arrives after 4 waiting cycles.
    d = blank(0); d.two_stage = 1; d.dbus_en = 1; d.wait_dly = 4; d.ev = 0;
    gen_instr(d); run_q(-1);

    // W=32 with compressed-aligned PC and MDU: misaligned target does not trap.
    d = blank(4); d.two_stage = 1; d.branch = 1; d.ctrl_mis = 1; d.mdu_op = 1;
    d.ev = 1; d.wait_dly = 2; d.stall_pct = 40;
    gen_instr(d); run_q(-1);

    for (int n = 0; n < 40; n++) begin
      d = blank(int'($urandom_range(0, NI - 1)));
      d.two_stage = 1'($urandom_range(0, 1));
      d.branch    = 1'($urandom_range(0, 1));
      d.cond      = 1'($urandom_range(0, 1));
      d.bne       = 1'($urandom_range(0, 1));
      d.alu_cmp   = 1'($urandom_range(0, 1));
      d.dbus_en   = 1'($urandom_range(0, 1));
      d.mem_mis   = 1'($urandom_range(0, 1));
      d.ctrl_mis  = 1'($urandom_range(0, 1));
      d.mdu_op    = 1'($urandom_range(0, 1));
      d.e_op      = ($urandom_range(0, 3) == 0);
      d.irq       = ($urandom_range(0, 3) == 0);
      d.fetch_dly = int'($urandom_range(0, 3));
      d.rd_dly    = int'($urandom_range(0, 3));
      d.wait_dly  = int'($urandom_range(0, 3));
      d.ev        = int'($urandom_range(0, 3));
      d.stall_pct = 20;
      gen_instr(d); run_q(-1);
    end

    // Reset while EXEC sits on beat 12 of a W=1 instruction.
    d = blank(0);
    gen_instr(d);
    run_q(2 + 12);
    q.delete();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    in_cur = '0;
    @(negedge clk);
    check(0, "reset_mid_exec", '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp = '0; exp.ibus_cyc = 1'b1;
    check(0, "refetch_after_reset", exp);

    d = blank(0); d.rd_dly = 2;
    gen_instr(d); run_q(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
